fpa8_ctrl: RTL and testbench

- Sequencing FSM for the 8-bit floating-point adder datapath (1 sign, 4 exponent, 3 mantissa bits, hidden one).
- Accepts a start/done handshake from the host.
- Drives every datapath enable and load-select in order: operand load, alignment, add/subtract, iterative normalization, result write.
- Reads the datapath's registered `normalize` status and bounds the normalization loop so a zero or degenerate mantissa cannot hang the block.

---
 rtl/fpa8_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fpa8_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpa8_ctrl.sv
// fpa8_ctrl: sequencing FSM for the 8-bit FP adder datapath.
// Optional cycle counter: define FPA_CTRL_CYCLE_COUNT_EN.
module fpa8_ctrl #(
  parameter int MAX_NORM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] normalize,
  output logic       en_mant_gt,
  output logic       en_mant_ls,
  output logic       en_mant_ans,
  output logic       en_exp_gt,
  output logic       en_exp_ls,
  output logic       en_exp_ans,
  output logic       en_sign_gt,
  output logic       en_sign_ls,
  output logic       en_sign_ans,
  output logic       en_s,
  output logic       ld_shift_mant_ls,
  output logic [1:0] ld_shift_mant_ans,
  output logic [1:0] ld_add_exp_ans,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] last_cycles
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ALIGN, ADD, NORM, WRITE, DONE
  } state_t;

  localparam logic [3:0] MAXN = 4'(MAX_NORM);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       shift_req;

  // State, norm counter and error flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // 11 from the datapath is treated like "already normalized"
  assign shift_req = (normalize == 2'b01) ||
                     (normalize == 2'b10);

  // Next-state and enable/select decode
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    err_d             = err_q;
    en_mant_gt        = 1'b0;
    en_mant_ls        = 1'b0;
    en_mant_ans       = 1'b0;
    en_exp_gt         = 1'b0;
    en_exp_ls         = 1'b0;
    en_exp_ans        = 1'b0;
    en_sign_gt        = 1'b0;
    en_sign_ls        = 1'b0;
    en_sign_ans       = 1'b0;
    en_s              = 1'b0;
    ld_shift_mant_ls  = 1'b0;
    ld_shift_mant_ans = 2'b00;
    ld_add_exp_ans    = 2'b00;
    done              = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        en_mant_gt = 1'b1;
        en_mant_ls = 1'b1;
        en_exp_gt  = 1'b1;
        en_exp_ls  = 1'b1;
        en_sign_gt = 1'b1;
        en_sign_ls = 1'b1;
        state_d    = ALIGN;
      end
      ALIGN: begin
        en_mant_ls       = 1'b1;
        ld_shift_mant_ls = 1'b1;
        state_d          = ADD;
      end
      ADD: begin
        en_mant_ans = 1'b1;
        en_exp_ans  = 1'b1;
        en_sign_ans = 1'b1;
        cnt_d       = '0;
        state_d     = NORM;
      end
      NORM: begin
        if (!shift_req) begin
          state_d = WRITE;
        end else if (cnt_q < MAXN) begin
          en_mant_ans       = 1'b1;
          en_exp_ans        = 1'b1;
          ld_shift_mant_ans = normalize;
          ld_add_exp_ans    = normalize;
          cnt_d             = cnt_q + 4'd1;
        end else begin
          err_d   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        en_s    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign err  = err_q;

`ifdef FPA_CTRL_CYCLE_COUNT_EN
  logic [7:0] cyc_q, cyc_d;
  logic [7:0] last_q, last_d;

  // Cycle counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      last_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      last_q <= last_d;
    end
  end

  // Count LOAD..DONE inclusive; LOAD itself is cycle 1
  always_comb begin
    cyc_d  = cyc_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (start) cyc_d = 8'd1;
    end else if (cyc_q != 8'hff) begin
      cyc_d = cyc_q + 8'd1;
    end
    if (state_q == DONE) last_d = cyc_q;
  end

  assign last_cycles = last_q;
`else
  assign last_cycles = 8'd0;
`endif

endmodule

// File: tb/tb_fpa8_ctrl.sv
// tb_fpa8_ctrl: random and directed checks of fpa8_ctrl
// against a cycle-timeline reference model.
module tb_fpa8_ctrl;

  localparam int MAXN = 4;
`ifdef FPA_CTRL_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] normalize;
  logic       en_mant_gt, en_mant_ls, en_mant_ans;
  logic       en_exp_gt, en_exp_ls, en_exp_ans;
  logic       en_sign_gt, en_sign_ls, en_sign_ans;
  logic       en_s, ld_shift_mant_ls;
  logic [1:0] ld_shift_mant_ans, ld_add_exp_ans;
  logic       busy, done, err;
  logic [7:0] last_cycles;

  fpa8_ctrl #(.MAX_NORM(MAXN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .normalize(normalize),
    .en_mant_gt(en_mant_gt),
    .en_mant_ls(en_mant_ls),
    .en_mant_ans(en_mant_ans),
    .en_exp_gt(en_exp_gt),
    .en_exp_ls(en_exp_ls),
    .en_exp_ans(en_exp_ans),
    .en_sign_gt(en_sign_gt),
    .en_sign_ls(en_sign_ls),
    .en_sign_ans(en_sign_ans),
    .en_s(en_s),
    .ld_shift_mant_ls(ld_shift_mant_ls),
    .ld_shift_mant_ans(ld_shift_mant_ans),
    .ld_add_exp_ans(ld_add_exp_ans),
    .busy(busy), .done(done), .err(err),
    .last_cycles(last_cycles)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // Model: position in the operation timeline.
  // m_cyc = 1 is the LOAD cycle; m_wr is the write
  // cycle once normalization has finished (-1 before).
  bit m_idle = 1'b1;
  int m_cyc  = 0;
  int m_k    = 0;
  int m_wr   = -1;
  bit m_err  = 1'b0;
  int m_last = 0;
  bit mon_en = 1'b0;

  bit es_watch = 1'b0;
  bit es_seen  = 1'b0;

  always @(negedge clk)
    if (es_watch && en_s) es_seen = 1'b1;

  function automatic logic [17:0] dut_vec();
    return {en_mant_gt, en_mant_ls, en_mant_ans,
            en_exp_gt, en_exp_ls, en_exp_ans,
            en_sign_gt, en_sign_ls, en_sign_ans,
            en_s, ld_shift_mant_ls,
            ld_shift_mant_ans, ld_add_exp_ans,
            busy, done};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      bit mg, ml, ma, eg, el, ea, sg, sl, sa;
      bit es, lsl, bz, dn, shift;
      bit [1:0] lma, lea;
      {mg, ml, ma, eg, el, ea, sg, sl, sa} = '0;
      {es, lsl, bz, dn} = '0;
      lma = 2'b00;
      lea = 2'b00;
      shift = (normalize == 2'b01) ||
              (normalize == 2'b10);
      if (!m_idle) begin
        bz = 1'b1;
        if (m_cyc == 1) begin
          {mg, ml, eg, el, sg, sl} = 6'h3f;
        end else if (m_cyc == 2) begin
          ml  = 1'b1;
          lsl = 1'b1;
        end else if (m_cyc == 3) begin
          ma = 1'b1;
          ea = 1'b1;
          sa = 1'b1;
        end else if (m_wr < 0) begin
          if (shift && m_k < MAXN) begin
            ma  = 1'b1;
            ea  = 1'b1;
            lma = normalize;
            lea = normalize;
          end
        end else if (m_cyc == m_wr) begin
          es = 1'b1;
        end else begin
          dn = 1'b1;
        end
      end
      check("outputs", dut_vec(),
            {mg, ml, ma, eg, el, ea, sg, sl, sa,
             es, lsl, lma, lea, bz, dn});
      check("err", err, m_err);
      check("last_cycles", last_cycles,
            CNT_EN ? m_last : 0);
      if (rst) begin
        m_idle = 1'b1;
        m_err  = 1'b0;
        m_last = 0;
      end else if (m_idle) begin
        if (start) begin
          m_idle = 1'b0;
          m_cyc  = 1;
          m_k    = 0;
          m_wr   = -1;
          m_err  = 1'b0;
        end
      end else begin
        if (m_cyc >= 4 && m_wr < 0) begin
          if (shift && m_k < MAXN) m_k++;
          else begin
            if (shift) m_err = 1'b1;
            m_wr = m_cyc + 1;
          end
        end else if (m_wr > 0 && m_cyc == m_wr + 1) begin
          m_idle = 1'b1;
          m_last = (m_cyc > 255) ? 255 : m_cyc;
        end
        m_cyc++;
      end
    end
  end

  // One operation; normalize = sval for NORM cycles
  // 4 .. 4+nsh-1, else 00. Checks hand-derived results.
  task automatic run_op(input logic [1:0] sval,
                        input int nsh,
                        input int exp_done,
                        input logic exp_err,
                        input int exp_lc);
    int got;
    got = -1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 30 && got < 0; i++) begin
      normalize = (i >= 4 && i < 4 + nsh) ? sval : 2'b00;
      @(negedge clk);
      if (i == 1) check("err_clear", err, 0);
      if (done) got = i;
      @(posedge clk);
      #1;
    end
    normalize = 2'b00;
    @(negedge clk);
    check("done_cycle", got, exp_done);
    check("err_after", err, exp_err);
    check("last_cyc_after", last_cycles,
          CNT_EN ? exp_lc : 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    normalize = 2'b00;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", dut_vec(), 0);
    check("rst_err", err, 0);
    check("rst_last", last_cycles, 0);
    @(posedge clk);
    #1;

    // one right shift
    run_op(2'b01, 1, 7, 1'b0, 7);
    // already normalized
    run_op(2'b00, 0, 6, 1'b0, 6);
    // zero result: guard trips after MAXN shifts
    run_op(2'b10, 99, 10, 1'b1, 10);
    // err clears on next start
    run_op(2'b01, 2, 8, 1'b0, 8);

    // reset in the middle of NORM
    es_seen  = 1'b0;
    es_watch = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    normalize = 2'b10;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    normalize = 2'b00;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_outputs", dut_vec(), 0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("abort_no_en_s", es_seen, 0);
    es_watch = 1'b0;

    // start held high: one op per 7 cycles
    n = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (done) n++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("held_start_dones", n, 10);
    repeat (12) begin
      @(posedge clk);
      #1;
    end

    // random traffic against the model
    repeat (500) begin
      rst = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) == 0);
      normalize = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    start = 1'b0;
    normalize = 2'b00;
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
